// File: rtl/arm_check_pkg.sv
// Shared definitions for the post-run data-memory self-check engine.
// The default sizes are the same ones the ARM core and its benches use.
package arm_check_pkg;

  localparam int DATA_MEM_SIZE_DEF = 64;
  localparam int INS_MEM_SIZE_DEF  = 32;

  // Checker FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } check_state_e;

endpackage

// File: rtl/check_compare_stage.sv
// Compare stage of the result checker.
// Delays the read strobe and address by one cycle so they line up with the
// memory and golden-ROM data, counts mismatching words and captures the
// lowest failing word.
module check_compare_stage
  import arm_check_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] exp_data,
  output logic              mismatch,
  output logic [CNT_W-1:0]  error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_got,
  output logic [DATA_W-1:0] first_err_exp
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;

  // A word is judged only in the cycle its read data is actually present.
  assign mismatch = valid_q && (rd_data != exp_data);

  // Delay pipeline, error counter and first-error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= 1'b0;
      addr_q         <= '0;
      error_count    <= '0;
      first_err_addr <= '0;
      first_err_got  <= '0;
      first_err_exp  <= '0;
    end else begin
      valid_q <= rd_en;
      addr_q  <= rd_addr;
      if (mismatch) begin
        // Counter is wide enough for every word failing; no saturation needed.
        error_count <= error_count + CNT_W'(1);
        // Addresses are walked upward, so the first mismatch seen is the lowest.
        if (error_count == '0) begin
          first_err_addr <= addr_q;
          first_err_got  <= rd_data;
          first_err_exp  <= exp_data;
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_result_checker.sv
// Post-run self-check engine. Waits for the core PC to leave instruction
// memory, then reads data memory back word by word over a spare read port
// and compares it against a golden ROM. Read-only: never writes, never
// stalls the core.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for the registered pc >= INS_MEM_SIZE*4 compare
// ST_SCAN  | issuing one read per cycle, addresses 0..DATA_MEM_SIZE-1
// ST_DRAIN | reads finished, last compare still in flight
// ST_DONE  | results held until reset; pc ignored
module data_mem_result_checker
  import arm_check_pkg::*;
#(
  parameter int DATA_MEM_SIZE = DATA_MEM_SIZE_DEF,
  parameter int INS_MEM_SIZE  = INS_MEM_SIZE_DEF,
  parameter int ADDR_W        = 6,
  parameter int DATA_W        = 32,
  parameter int CNT_W         = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [ADDR_W-1:0] exp_rd_addr,
  input  logic [DATA_W-1:0] exp_rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_got,
  output logic [DATA_W-1:0] first_err_exp
);

  localparam logic [31:0]       PC_LIMIT  = 32'(INS_MEM_SIZE * 4);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_MEM_SIZE - 1);

  check_state_e state;
  logic         trig_q;
  logic         mismatch;

  // The golden ROM is addressed in lockstep with data memory.
  assign exp_rd_addr = mem_rd_addr;

  // Registered trigger compare. Deliberately sampled during reset as well, so
  // a pc already past the program end starts the scan on the first edge
  // after reset is released.
  always_ff @(posedge clk) begin
    trig_q <= (pc >= PC_LIMIT);
  end

  // Scan sequencing FSM and address generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig_q) begin
            state       <= ST_SCAN;
            busy        <= 1'b1;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= '0;
          end
        end
        ST_SCAN: begin
          if (mem_rd_addr == LAST_ADDR) begin
            state     <= ST_DRAIN;
            mem_rd_en <= 1'b0;
          end else begin
            mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          // The last word is compared on this same edge, so its result is
          // folded into pass directly rather than read from the counter.
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (error_count == '0) && !mismatch;
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  check_compare_stage #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_compare (
    .clk            (clk),
    .rst            (rst),
    .rd_en          (mem_rd_en),
    .rd_addr        (mem_rd_addr),
    .rd_data        (mem_rd_data),
    .exp_data       (exp_rd_data),
    .mismatch       (mismatch),
    .error_count    (error_count),
    .first_err_addr (first_err_addr),
    .first_err_got  (first_err_got),
    .first_err_exp  (first_err_exp)
  );

endmodule

// File: tb/tb_data_mem_result_checker.sv
// Bench for data_mem_result_checker: bench-side data memory and golden ROM,
// a word-list reference model of the expected results, and a per-cycle check
// of the scan timeline.
module tb_data_mem_result_checker;

  localparam int DMS    = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       pc = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic [ADDR_W-1:0] exp_rd_addr;
  logic [DATA_W-1:0] exp_rd_data = '0;
  logic              busy, done, pass;
  logic [CNT_W-1:0]  error_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_got, first_err_exp;

  logic [31:0] mem  [DMS];
  logic [31:0] gold [DMS];

  int checks   = 0;
  int failures = 0;

  data_mem_result_checker dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .exp_rd_addr    (exp_rd_addr),
    .exp_rd_data    (exp_rd_data),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .error_count    (error_count),
    .first_err_addr (first_err_addr),
    .first_err_got  (first_err_got),
    .first_err_exp  (first_err_exp)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data valid one cycle after address.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    exp_rd_data <= gold[exp_rd_addr];
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: results follow directly from the two word lists.
  task automatic model(output int cnt, output int fa, output logic [31:0] fg, output logic [31:0] fe);
    cnt = 0; fa = 0; fg = '0; fe = '0;
    for (int i = 0; i < DMS; i++) begin
      if (mem[i] != gold[i]) begin
        if (cnt == 0) begin fa = i; fg = mem[i]; fe = gold[i]; end
        cnt++;
      end
    end
  endtask

  task automatic chk_results(input string tag);
    int cnt, fa;
    logic [31:0] fg, fe;
    model(cnt, fa, fg, fe);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_count"}, 64'(error_count), 64'(cnt));
    chk({tag, "_pass"}, 64'(pass), 64'(cnt == 0));
    chk({tag, "_faddr"}, 64'(first_err_addr), 64'(fa));
    chk({tag, "_fgot"}, 64'(first_err_got), 64'(fg));
    chk({tag, "_fexp"}, 64'(first_err_exp), 64'(fe));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rden"}, 64'(mem_rd_en), 64'd0);
    chk({tag, "_addr"}, 64'(mem_rd_addr), 64'd0);
    chk({tag, "_eaddr"}, 64'(exp_rd_addr), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_count"}, 64'(error_count), 64'd0);
    chk({tag, "_faddr"}, 64'(first_err_addr), 64'd0);
    chk({tag, "_fgot"}, 64'(first_err_got), 64'd0);
    chk({tag, "_fexp"}, 64'(first_err_exp), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pc  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise pc past the threshold and check every cycle of the scan timeline.
  // Edge c=1 samples pc; busy from c=2, reads at c=2..65 with address c-2,
  // done from c=67 (66 cycles after the sampling edge).
  task automatic scan_and_check(input string tag, input bit drop_pc);
    @(negedge clk);
    pc = 32'h80 + ($urandom_range(0, 15) << 2);
    for (int c = 1; c <= 68; c++) begin
      @(posedge clk);
      #1;
      if (drop_pc && c == 1) pc = 32'h10;
      chk({tag, "_t_busy"}, 64'(busy), 64'(c >= 2 && c <= 66));
      chk({tag, "_t_done"}, 64'(done), 64'(c >= 67));
      chk({tag, "_t_rden"}, 64'(mem_rd_en), 64'(c >= 2 && c <= 65));
      if (c >= 2 && c <= 65) chk({tag, "_t_addr"}, 64'(mem_rd_addr), 64'(c - 2));
      chk({tag, "_t_eaddr"}, 64'(exp_rd_addr), 64'(mem_rd_addr));
    end
    chk_results(tag);
  endtask

  task automatic fill_random(input int nerr);
    for (int i = 0; i < DMS; i++) begin
      gold[i] = $urandom;
      mem[i]  = gold[i];
    end
    for (int k = 0; k < nerr; k++) begin
      int j;
      j = $urandom_range(0, DMS - 1);
      mem[j] = gold[j] ^ ($urandom | 32'h1);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < DMS; i++) begin gold[i] = 32'(i); mem[i] = 32'(i); end

    // Reset state
    do_reset();
    #1;
    chk_all_zero("reset");

    // 1. Memory matches golden
    scan_and_check("match", 1'b0);
    chk("match_lit_pass", 64'(pass), 64'd1);
    chk("match_lit_count", 64'(error_count), 64'd0);

    // 2. Mismatch at words 5 and 63
    do_reset();
    mem[5]  = 32'hDEADBEEF;
    mem[63] = 32'hDEADBEEF;
    scan_and_check("two_err", 1'b0);
    chk("two_lit_count", 64'(error_count), 64'd2);
    chk("two_lit_pass", 64'(pass), 64'd0);
    chk("two_lit_faddr", 64'(first_err_addr), 64'd5);
    chk("two_lit_fgot", 64'(first_err_got), 64'hDEADBEEF);
    chk("two_lit_fexp", 64'(first_err_exp), 64'h5);
    // DONE ignores pc and holds results
    @(negedge clk); pc = 32'h0;
    repeat (5) @(posedge clk);
    #1;
    chk_results("two_hold");

    // 3. pc just below threshold forever
    do_reset();
    @(negedge clk); pc = 32'h7C;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_rden", 64'(mem_rd_en), 64'd0);
    end

    // 4. Reset mid-scan at address 20, then full rescan
    do_reset();
    for (int i = 0; i < DMS; i++) begin gold[i] = 32'(i); mem[i] = 32'(i); end
    mem[3] = 32'h1234;
    @(negedge clk); pc = 32'h80;
    n = 0;
    while (!(busy && mem_rd_addr == 6'd20) && n < 200) begin @(posedge clk); #1; n++; end
    chk("mid_reach20", 64'(n < 200), 64'd1);
    chk("mid_cnt_before", 64'(error_count), 64'd1);
    @(negedge clk); rst = 1'b1; pc = '0;
    @(posedge clk); #1;
    chk_all_zero("mid_rst");
    @(negedge clk); rst = 1'b0;
    fill_random(3);
    scan_and_check("rescan", 1'b0);

    // 5. pc above threshold for one cycle only
    do_reset();
    fill_random(1);
    scan_and_check("oneshot", 1'b1);

    // 6. Every word differs
    do_reset();
    for (int i = 0; i < DMS; i++) begin gold[i] = 32'(i); mem[i] = ~32'(i); end
    scan_and_check("all_err", 1'b0);
    chk("all_lit_count", 64'(error_count), 64'd64);
    chk("all_lit_faddr", 64'(first_err_addr), 64'd0);
    chk("all_lit_fgot", 64'(first_err_got), 64'hFFFFFFFF);

    // pc already past threshold when reset releases
    fill_random(2);
    @(negedge clk); rst = 1'b1; pc = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_busy", 64'(busy), 64'd1);
    chk("rel_rden", 64'(mem_rd_en), 64'd1);
    chk("rel_addr", 64'(mem_rd_addr), 64'd0);
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    chk("rel_latency", 64'(n), 64'd65);
    chk_results("rel");

    // Randomized scans
    for (int r = 0; r < 4; r++) begin
      do_reset();
      fill_random($urandom_range(0, 6));
      scan_and_check("rand", 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
